// File: rtl/three_op_pkg.sv
// Shared types and constants for the three-operand adder datapath.
// Provides the default adder sum width and the accumulator FSM states.
package three_op_pkg;

    localparam int DEF_SUM_W = 9;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/three_op_sum_accum.sv
// Block accumulator for three-operand adder sums.
// Ports: clk, rst (async high); in_valid/in_ready/in_sum sample input;
// flush closes a partial block; out_valid/out_ready handshake with
// out_total (block sum mod 2^ACC_W), out_count and sticky out_ovf.
module three_op_sum_accum
    import three_op_pkg::*;
#(
    parameter int SUM_W     = DEF_SUM_W,
    parameter int ACC_W     = 12,
    parameter int BLOCK_LEN = 8,
    localparam int CNT_W    = $clog2(BLOCK_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_t             state;
    state_t             state_n;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic               ovf;
    logic               ovf_n;
    logic               load;
    logic [ACC_W:0]     sum_ext;

    // Ready depends on state alone so out_ready never reaches in_ready.
    assign in_ready = (state == ACCUM);

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        ovf_n   = ovf;
        load    = 1'b0;
        // Extra MSB captures the carry out of the accumulator width.
        sum_ext = {1'b0, acc} + (ACC_W + 1)'(in_sum);
        unique case (state)
            ACCUM: begin
                if (in_valid) begin
                    acc_n = sum_ext[ACC_W-1:0];
                    cnt_n = cnt + CNT_W'(1);
                    ovf_n = ovf | sum_ext[ACC_W];
                end
                // Flush sees the post-accept count, so a same-cycle
                // sample lands in the closing block.
                if ((in_valid && (cnt_n == CNT_W'(BLOCK_LEN))) ||
                    (flush && (cnt_n != '0))) begin
                    load    = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = ACCUM;
                end
            end
            default: begin
                state_n = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_total <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                out_total <= acc_n;
                out_count <= cnt_n;
                out_ovf   <= ovf_n;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
            end else begin
                acc <= acc_n;
                cnt <= cnt_n;
                ovf <= ovf_n;
                if ((state == HOLD) && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/three_op_sum_accum.md
# three_op_sum_accum

Downstream consumer of the three-operand adder: accepts its 9-bit unsigned sums through a valid/ready handshake and accumulates them in blocks of `BLOCK_LEN` samples. It presents each block total, with its sample count and a sticky overflow flag, on a valid/ready output port. A `flush` input closes a partial block early. The block sits between the adder output and any block-rate consumer, decoupling the two with a one-deep output hold.

## Interface
- `SUM_W`, 9, width of the incoming adder sum (unsigned)
- `ACC_W`, 12, accumulator/total width; default covers 8 × 511 = 4088 exactly
- `BLOCK_LEN`, 8, samples per block; legal range ≥ 1
- `CNT_W`, $clog2(BLOCK_LEN+1), sample-count width (derived, not overridden)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  `in_sum` valid this cycle
- `in_ready`  out  1  block can accept a sample this cycle
- `in_sum`  in  SUM_W  adder result (unsigned)
- `flush`  in  1  close current partial block (level, sampled each cycle)
- `out_valid`  out  1  block result held on outputs
- `out_ready`  in  1  downstream accepts result
- `out_total`  out  ACC_W  block sum, modulo 2^ACC_W
- `out_count`  out  CNT_W  samples contained in `out_total`
- `out_ovf`  out  1  a carry out of `ACC_W` occurred within this block

## Operation
- States: `ACCUM`, `HOLD`. Reset → `ACCUM`, accumulator = 0, count = 0, `out_valid` = 0, `out_total` = 0, `out_count` = 0, `out_ovf` = 0.
- `ACCUM`:
  - `in_ready` = 1.
  - Accept (`in_valid & in_ready`) → acc ← acc + zero-extended `in_sum`, count ← count + 1, and ovf ← ovf | carry-out.
  - If the accept makes count = `BLOCK_LEN` → `HOLD`.
  - `flush` with count (after any same-cycle accept) ≥ 1 → `HOLD`. The same-cycle sample is included.
  - `flush` with count = 0 and no accept → ignored; stays in `ACCUM`.
- Entering `HOLD`: `out_total`/`out_count`/`out_ovf` are loaded from the post-update accumulator, count and ovf. `out_valid` ← 1. Accumulator, count and ovf are cleared.
- `HOLD`:
  - `in_ready` = 0; `flush` ignored.
  - Outputs stable until `out_ready` = 1.
  - `out_valid & out_ready` → `out_valid` ← 0, back to `ACCUM`.
- Arithmetic: unsigned, wraps modulo 2^ACC_W. `out_ovf` is sticky per block only.
- `in_ready` is a function of state only, with no combinational path from `out_ready`. This costs one bubble cycle per block.

## Timing
- Results appear 1 cycle after the closing accept: `out_valid` rises on the edge that accepts sample `BLOCK_LEN` (or on the flush edge).
- Throughput: `BLOCK_LEN` samples per `BLOCK_LEN` + 1 cycles minimum, when `out_ready` is held high.
- `out_ready` asserted in the same cycle `out_valid` rises → handshake completes that cycle, and the next edge returns to `ACCUM`.
- `BLOCK_LEN` = 1 → every accepted sample produces a result with count 1.
- `rst` asserted mid-block or in `HOLD` → immediate return to reset values. The partial block and any held result are discarded.

## Structure
- Shared package `three_op_pkg`:
  - `SUM_W` default constant
  - state enum `{ACCUM, HOLD}`
- Single module, no sub-module. The datapath is one adder plus registers and the FSM is two states, so splitting adds nothing.

## Test plan
- Eight accepts of `in_sum` = 44 (25+1+18), `out_ready` = 1 → `out_total` = 352, `out_count` = 8, `out_ovf` = 0. `out_valid` is high exactly 1 cycle, on the edge after the 8th accept.
- Eight accepts of 511 → `out_total` = 4088, `ovf` = 0. Rerun with `ACC_W` = 11 → `out_total` = 2040 and `out_ovf` = 1.
- Three accepts (10, 20, 30), then `flush` alone → `out_total` = 60, `out_count` = 3. Separately, `flush` together with a 4th accept of 40 → total 100, count 4. `flush` with count 0 → no `out_valid`.
- `out_ready` = 0 for 5 cycles after a block completes → outputs stable, `in_ready` = 0, `in_valid` samples are not consumed. Release → next block starts from 0.
- `rst` pulsed asynchronously after 5 accepts and again while in `HOLD` → all outputs 0 immediately. A following 8-sample block of 44 totals 352.
- Random `in_valid`/`out_ready` gaps, 1000 samples → sum of all `out_total` equals the scoreboard modulo 2^ACC_W per block, and no sample is lost or duplicated.
